bcd_updown_counter: RTL and testbench
=====================================

Name: bcd_updown_counter

Overview:
- Parametrised multi-digit synchronous BCD counter; next generation of the team's single-decade 4-bit BCD counter.
- Adds digit count, up/down mode, enable, synchronous parallel load with digit validation, and a terminal-count output for cascading instances.
- Used as a decimal event/time counter feeding display and timer logic.

Parameters:
DIGITS, 4, number of BCD decades (>=1); counter range 0 to 10^DIGITS-1.

Ports:
CLK  input  1  clock; all state changes on rising edge.
RST  input  1  synchronous, active-high reset.
EN  input  1  count enable; one step per clock while high.
UP  input  1  direction: 1 = increment, 0 = decrement.
LOAD  input  1  synchronous parallel load strobe.
LOAD_VAL  input  4*DIGITS  packed BCD load value; digit i at bits [4i+3:4i]; digit 0 is least significant.
COUNT  output  4*DIGITS  registered packed BCD count, same packing as LOAD_VAL.
TC  output  1  combinational terminal count for cascading.
LOAD_ERR  output  1  registered one-cycle flag: last load contained an invalid digit.

Behaviour:
- One clock (CLK). Reset is synchronous and active-high (RST). No asynchronous paths into state.
- Priority on each rising CLK edge: RST > LOAD > EN > hold.
- RST=1:
  - COUNT <= 0, LOAD_ERR <= 0.
  - TC then reflects EN & ~UP, since COUNT is all-zeros.
- LOAD=1 (RST=0):
  - Each digit of LOAD_VAL is loaded; any digit > 9 (values 10-15) is loaded as 0.
  - LOAD_ERR <= 1 if any digit was > 9, else 0.
  - LOAD overrides EN; no count step occurs that cycle.
- LOAD=0 (RST=0): LOAD_ERR <= 0, so the flag is exactly one cycle wide per bad load.
- EN=1, UP=1, LOAD=0:
  - Digit 0 increments; digit i (i>0) increments only when digits 0..i-1 are all 9.
  - Any digit stepping past 9 becomes 0.
  - All-9s wraps to all-0s in one cycle.
- EN=1, UP=0, LOAD=0:
  - Digit 0 decrements; digit i decrements only when digits 0..i-1 are all 0.
  - Any digit stepping below 0 becomes 9.
  - All-0s wraps to all-9s.
- EN=0: COUNT holds.
- UP may change on any cycle; the new direction applies at the next enabled edge. No state depends on the previous direction.
- TC = EN & (UP ? all digits == 9 : all digits == 0).
  - Combinational from registered COUNT and live EN/UP.
  - High exactly in the cycle before the wrap edge; chaining TC into the EN of the next instance yields a wider counter.
- Latency: COUNT reflects an EN/LOAD action one clock after it is sampled. No pipeline, no multicycle operations.
- Invariant: every digit of COUNT is always in 0..9, including after reset, after a load and after a wrap.
- RST asserted mid-count or in the same cycle as LOAD: reset wins, and the load is discarded (LOAD_ERR = 0).
- Arithmetic is per-digit 4-bit, with no binary-to-BCD conversion. The carry/borrow chain is ripple-free in time: all digits update on the same edge.

Test Plan:
1. DIGITS=2, RST=1 for 2 cycles, then EN=1, UP=1 for 100 cycles -> COUNT steps 00,01..09,10..99,00; TC=1 only while COUNT=99.
2. DIGITS=2, LOAD=1, LOAD_VAL=0x10, then EN=1, UP=0 -> COUNT 10,09,08..00,99; TC=1 only while COUNT=00 with UP=0.
3. LOAD=1, LOAD_VAL=0x3C -> next cycle COUNT=0x30, LOAD_ERR=1 for exactly one cycle. Then LOAD_VAL=0x42 -> COUNT=0x42, LOAD_ERR=0.
4. COUNT=0x57, LOAD=1 and EN=1 in the same cycle with LOAD_VAL=0x20 -> COUNT=0x20, no increment. Next cycle (EN=1, UP=1) -> 0x21.
5. COUNT=0x45, EN=1, assert RST together with LOAD=1 and LOAD_VAL=0xFF -> COUNT=0x00, LOAD_ERR=0. Then EN=0 for 5 cycles -> COUNT holds 0x00, TC=0.
6. DIGITS=4, two instances chained (TC of low into EN of high), UP=1, start at low=9998 -> low 9999 then 0000, and the high instance increments on exactly that wrap edge; direction toggled mid-run reverses on the next edge.

Source files
------------

// File: rtl/bcd_updown_counter.sv
// Multi-digit synchronous BCD up/down counter with parallel load, digit
// validation on load, and a combinational terminal count for cascading.
module bcd_updown_counter #(
  parameter int DIGITS = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  EN,
  input  logic                  UP,
  input  logic                  LOAD,
  input  logic [4*DIGITS-1:0]   LOAD_VAL,
  output logic [4*DIGITS-1:0]   COUNT,
  output logic                  TC,
  output logic                  LOAD_ERR
);

  logic [4*DIGITS-1:0] count_q, count_d;
  logic                loadErr_q, loadErr_d;
  logic                carry;
  logic                allNine, allZero;

  // Next-state logic: load (with per-digit sanitising) takes priority over counting.
  // carry means every lower digit sits at its wrap value, so this digit steps too.
  always_comb begin
    count_d   = count_q;
    loadErr_d = 1'b0;
    carry     = 1'b1;
    if (LOAD) begin
      for (int i = 0; i < DIGITS; i++) begin
        if (LOAD_VAL[4*i +: 4] > 4'd9) begin
          count_d[4*i +: 4] = 4'd0;
          loadErr_d         = 1'b1;
        end else begin
          count_d[4*i +: 4] = LOAD_VAL[4*i +: 4];
        end
      end
    end else if (EN) begin
      for (int i = 0; i < DIGITS; i++) begin
        if (carry) begin
          if (UP) begin
            count_d[4*i +: 4] = (count_q[4*i +: 4] == 4'd9) ? 4'd0 : count_q[4*i +: 4] + 4'd1;
          end else begin
            count_d[4*i +: 4] = (count_q[4*i +: 4] == 4'd0) ? 4'd9 : count_q[4*i +: 4] - 4'd1;
          end
        end
        carry = carry & (UP ? (count_q[4*i +: 4] == 4'd9) : (count_q[4*i +: 4] == 4'd0));
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      count_q   <= '0;
      loadErr_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      loadErr_q <= loadErr_d;
    end
  end

  // TC uses live EN/UP so a chained instance steps on the same edge as our wrap.
  assign allNine  = (count_q == {DIGITS{4'h9}});
  assign allZero  = (count_q == '0);
  assign TC       = EN & (UP ? allNine : allZero);
  assign COUNT    = count_q;
  assign LOAD_ERR = loadErr_q;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Scoreboard bench: a 2-digit instance plus two chained 4-digit instances,
// driven on the falling edge and checked just after each rising edge.
module tb_bcd_updown_counter;

  typedef struct {
    string       name;
    logic [7:0]  c2;
    logic        tc2;
    logic        err2;
    logic [15:0] lo;
    logic [15:0] hi;
    logic        tcLo;
  } exp_t;

  logic        clock = 1'b0;
  logic        rst = 1'b1;
  logic        en2 = 1'b0, up2 = 1'b1, load2 = 1'b0;
  logic [7:0]  val2 = '0;
  logic        chEn = 1'b0, chUp = 1'b1, chLoad = 1'b0;
  logic [15:0] chValLo = '0, chValHi = '0;

  logic [7:0]  count2;
  logic        tc2, err2;
  logic [15:0] countLo, countHi;
  logic        tcLo, tcHi, errLo, errHi;

  exp_t        expQ[$];
  int          checks = 0;
  int          errors = 0;
  logic [7:0]  lastC2 = '0;

  always #5 clock = ~clock;

  bcd_updown_counter #(.DIGITS(2)) dut2 (
    .CLK(clock), .RST(rst), .EN(en2), .UP(up2), .LOAD(load2), .LOAD_VAL(val2),
    .COUNT(count2), .TC(tc2), .LOAD_ERR(err2)
  );

  bcd_updown_counter #(.DIGITS(4)) dutLo (
    .CLK(clock), .RST(rst), .EN(chEn), .UP(chUp), .LOAD(chLoad), .LOAD_VAL(chValLo),
    .COUNT(countLo), .TC(tcLo), .LOAD_ERR(errLo)
  );

  bcd_updown_counter #(.DIGITS(4)) dutHi (
    .CLK(clock), .RST(rst), .EN(tcLo), .UP(chUp), .LOAD(chLoad), .LOAD_VAL(chValHi),
    .COUNT(countHi), .TC(tcHi), .LOAD_ERR(errHi)
  );

  task automatic checkOutput(input string name, input string field,
                             input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s.%s: got %h expected %h", name, field, actual, expected);
    end
  endtask

  // Monitor: the DUTs present a new result after every rising edge.
  initial begin
    exp_t x;
    forever begin
      @(posedge clock);
      #1;
      if (expQ.size() > 0) begin
        x = expQ.pop_front();
        checkOutput(x.name, "count2", {8'h0, count2}, {8'h0, x.c2});
        checkOutput(x.name, "tc2", {15'h0, tc2}, {15'h0, x.tc2});
        checkOutput(x.name, "err2", {15'h0, err2}, {15'h0, x.err2});
        checkOutput(x.name, "countLo", countLo, x.lo);
        checkOutput(x.name, "countHi", countHi, x.hi);
        checkOutput(x.name, "tcLo", {15'h0, tcLo}, {15'h0, x.tcLo});
      end
    end
  end

  task automatic applyStimulus(input logic r, input logic e, input logic u, input logic l,
                               input logic [7:0] v, input logic ce, input logic cu,
                               input logic cl, input logic [15:0] cvl,
                               input logic [15:0] cvh, input exp_t x);
    @(negedge clock);
    rst = r; en2 = e; up2 = u; load2 = l; val2 = v;
    chEn = ce; chUp = cu; chLoad = cl; chValLo = cvl; chValHi = cvh;
    expQ.push_back(x);
  endtask

  task automatic step2(input string name, input logic r, input logic e, input logic u,
                       input logic l, input logic [7:0] v,
                       input logic [7:0] c, input logic tc, input logic err);
    exp_t x;
    x = '{name: name, c2: c, tc2: tc, err2: err, lo: 16'h0, hi: 16'h0, tcLo: 1'b0};
    lastC2 = c;
    applyStimulus(r, e, u, l, v, 1'b0, 1'b1, 1'b0, 16'h0, 16'h0, x);
  endtask

  task automatic stepCh(input string name, input logic e, input logic u, input logic l,
                        input logic [15:0] vl, input logic [15:0] vh,
                        input logic [15:0] lo, input logic [15:0] hi, input logic tc);
    exp_t x;
    x = '{name: name, c2: lastC2, tc2: 1'b0, err2: 1'b0, lo: lo, hi: hi, tcLo: tc};
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, e, u, l, vl, vh, x);
  endtask

  function automatic logic [7:0] toBcd2(input int n);
    return 8'(((n / 10) << 4) | (n % 10));
  endfunction

  initial begin
    int n;
    $display("[TB] start");
    step2("reset0", 1, 0, 1, 0, 8'h00, 8'h00, 0, 0);
    step2("reset1", 1, 0, 1, 0, 8'h00, 8'h00, 0, 0);

    for (int k = 1; k <= 100; k++) begin
      n = k % 100;
      step2("up", 0, 1, 1, 0, 8'h00, toBcd2(n), (n == 99), 0);
    end

    step2("load10", 0, 0, 1, 1, 8'h10, 8'h10, 0, 0);
    for (int j = 1; j <= 12; j++) begin
      n = (110 - j) % 100;
      step2("down", 0, 1, 0, 0, 8'h00, toBcd2(n), (n == 0), 0);
    end

    step2("load3C", 0, 0, 1, 1, 8'h3C, 8'h30, 0, 1);
    step2("load42", 0, 0, 1, 1, 8'h42, 8'h42, 0, 0);
    step2("loadAF", 0, 0, 1, 1, 8'hAF, 8'h00, 0, 1);
    step2("idleErr", 0, 0, 1, 0, 8'h00, 8'h00, 0, 0);

    step2("load57", 0, 0, 1, 1, 8'h57, 8'h57, 0, 0);
    step2("loadOverEn", 0, 1, 1, 1, 8'h20, 8'h20, 0, 0);
    step2("upAfterLoad", 0, 1, 1, 0, 8'h00, 8'h21, 0, 0);

    step2("load45", 0, 0, 1, 1, 8'h45, 8'h45, 0, 0);
    step2("rstOverLoad", 1, 1, 1, 1, 8'hFF, 8'h00, 0, 0);
    for (int k = 0; k < 5; k++) step2("holdZero", 0, 0, 1, 0, 8'h00, 8'h00, 0, 0);
    step2("rstDownTc", 1, 1, 0, 0, 8'h00, 8'h00, 1, 0);
    step2("settle", 0, 0, 1, 0, 8'h00, 8'h00, 0, 0);

    stepCh("chLoad", 0, 1, 1, 16'h9998, 16'h0005, 16'h9998, 16'h0005, 0);
    stepCh("chUp1", 1, 1, 0, 16'h0, 16'h0, 16'h9999, 16'h0005, 1);
    stepCh("chWrap", 1, 1, 0, 16'h0, 16'h0, 16'h0000, 16'h0006, 0);
    stepCh("chUp2", 1, 1, 0, 16'h0, 16'h0, 16'h0001, 16'h0006, 0);
    stepCh("chDown1", 1, 0, 0, 16'h0, 16'h0, 16'h0000, 16'h0006, 1);
    stepCh("chBorrow", 1, 0, 0, 16'h0, 16'h0, 16'h9999, 16'h0005, 0);
    stepCh("chUpAgain", 1, 1, 0, 16'h0, 16'h0, 16'h0000, 16'h0006, 0);
    stepCh("chHold", 0, 1, 0, 16'h0, 16'h0, 16'h0000, 16'h0006, 0);

    repeat (3) @(posedge clock);
    #2;
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d pending expected 0", expQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
